card_dealer: RTL and testbench

//   Shuffles a 52-card deck with a Fisher-Yates pass driven by a 6-bit LFSR.

---
 rtl/card_dealer_if.sv | 22 ++
 rtl/card_dealer.sv | 107 ++++++++++
 tb/tb_card_dealer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Deal request/status and the two dealt 5-card hands between dealer and its consumer.
interface card_dealer_if;
    logic       deal;
    logic       busy;
    logic       valid;
    logic [5:0] a1, a2, a3, a4, a5;
    logic [5:0] b1, b2, b3, b4, b5;

    modport master (
        output deal,
        input  busy, valid,
        input  a1, a2, a3, a4, a5,
        input  b1, b2, b3, b4, b5
    );

    modport slave (
        input  deal,
        output busy, valid,
        output a1, a2, a3, a4, a5,
        output b1, b2, b3, b4, b5
    );
endinterface

// File: rtl/card_dealer.sv
// LFSR-driven Fisher-Yates shuffle of a 52-card deck, dealing deck[0..4] to
// player 1 and deck[5..9] to player 2.
module card_dealer #(
    parameter logic [5:0] LFSR_SEED = 6'd1
) (
    input  logic         clk,
    input  logic         rst,
    card_dealer_if.slave bus
);
    localparam int unsigned DECK_N = 52;
    localparam int unsigned HAND_N = 10;
    localparam int unsigned CARD_W = 6;

    // A zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [CARD_W-1:0] SEED_EFF = (LFSR_SEED == 6'd0) ? 6'd1 : LFSR_SEED;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_SHUFFLE = 3'd2;
    localparam logic [2:0] ST_DEAL    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CARD_W-1:0] lfsr_q, lfsr_next;
    logic [CARD_W-1:0] i_q;
    logic [CARD_W-1:0] r;
    logic              accept;
    logic              busy_q, valid_q;
    logic [CARD_W-1:0] deck   [DECK_N];
    logic [CARD_W-1:0] hand_q [HAND_N];

    assign lfsr_next = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
    assign r         = lfsr_q - 6'd1;
    assign accept    = (r <= i_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bus.deal) state_d = ST_INIT;
            ST_INIT:          state_d = ST_SHUFFLE;
            ST_SHUFFLE:       if (accept && (i_q == 6'd1)) state_d = ST_DEAL;
            ST_DEAL:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Shuffle control, status flags and the registered hands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= SEED_EFF;
            i_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int k = 0; k < int'(HAND_N); k++) hand_q[k] <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.deal) begin
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                ST_INIT: i_q <= 6'd51;
                ST_SHUFFLE: begin
                    lfsr_q <= lfsr_next;
                    if (accept && (i_q != 6'd1)) i_q <= i_q - 6'd1;
                end
                ST_DEAL: begin
                    for (int k = 0; k < int'(HAND_N); k++) hand_q[k] <= deck[k];
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Deck storage needs no reset: INIT rebuilds it before every shuffle.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int k = 0; k < int'(DECK_N); k++) deck[k] <= CARD_W'(k);
        end else if ((state_q == ST_SHUFFLE) && accept) begin
            deck[i_q] <= deck[r];
            deck[r]   <= deck[i_q];
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.a1    = hand_q[0];
    assign bus.a2    = hand_q[1];
    assign bus.a3    = hand_q[2];
    assign bus.a4    = hand_q[3];
    assign bus.a5    = hand_q[4];
    assign bus.b1    = hand_q[5];
    assign bus.b2    = hand_q[6];
    assign bus.b3    = hand_q[7];
    assign bus.b4    = hand_q[8];
    assign bus.b5    = hand_q[9];
endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a Fisher-Yates model driven by its own LFSR
// predicts each hand and its latency when a deal is accepted.
module tb_card_dealer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    card_dealer_if bus ();
    card_dealer #(.LFSR_SEED(6'd1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [9:0][5:0] hand;
        int              lat;
    } exp_t;

    exp_t            exp_q[$];
    int              errors = 0;
    int              checks = 0;
    logic [5:0]      m_lfsr;
    logic [9:0][5:0] t2_hand;
    int              t2_lat;

    function automatic logic [9:0][5:0] get_hand();
        return {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1,
                bus.a5, bus.a4, bus.a3, bus.a2, bus.a1};
    endfunction

    // Model one full deal from the current model LFSR and queue its result.
    function automatic void model_push();
        int         deck[52];
        int         i, r, cyc, tmp;
        logic [5:0] l;
        exp_t       e;
        l = m_lfsr;
        for (int k = 0; k < 52; k++) deck[k] = k;
        i = 51;
        cyc = 0;
        while (cyc < 100000) begin
            r = int'(l) - 1;
            l = {l[4:0], l[5] ^ l[4]};
            cyc++;
            if (r <= i) begin
                tmp = deck[i]; deck[i] = deck[r]; deck[r] = tmp;
                if (i == 1) break;
                i--;
            end
        end
        m_lfsr = l;
        for (int k = 0; k < 10; k++) e.hand[k] = 6'(deck[k]);
        e.lat = cyc + 2;
        exp_q.push_back(e);
    endfunction

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.deal = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 6'd1;
        exp_q.delete();
    endtask

    // Pulse deal for one cycle; returns at the falling edge right after acceptance.
    task automatic start_deal();
        @(negedge clk);
        bus.deal = 1'b1;
        model_push();
        @(negedge clk);
        bus.deal = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int n0, output int n);
        n = n0;
        while (bus.valid !== 1'b1 && n < 3300) begin
            @(negedge clk);
            n++;
        end
        if (bus.valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s valid_timeout: no valid after %0d cycles (required <= 3215)", nm, n);
            finish_now();
        end
    endtask

    task automatic check_deal(input string nm, input int n, output logic [9:0][5:0] eh);
        exp_t            e;
        logic [9:0][5:0] h;
        bit              bad;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: valid seen with no deal expected", nm);
            eh = '0;
            return;
        end
        e  = exp_q.pop_front();
        eh = e.hand;
        h  = get_hand();
        checks++;
        if (h !== e.hand) begin
            errors++;
            $display("FAIL %s hand: got %h required %h", nm, h, e.hand);
        end
        checks++;
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", nm, n, e.lat);
        end
        bad = 1'b0;
        for (int x = 0; x < 10; x++) begin
            if (h[x] > 6'd51) bad = 1'b1;
            for (int y = x + 1; y < 10; y++) if (h[x] == h[y]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s distinct: got %h required ten distinct cards <= 51", nm, h);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b required 0", nm, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.deal = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b required 0", bus.busy); end
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL t1_valid: got %b required 0", bus.valid); end
        checks++;
        if (get_hand() !== '0) begin errors++; $display("FAIL t1_hand: got %h required 0", get_hand()); end
        checks++;
        if (dut.lfsr_q !== 6'd1) begin errors++; $display("FAIL t1_lfsr: got %0d required 1", dut.lfsr_q); end
        rst = 1'b0;
        m_lfsr = 6'd1;
        exp_q.delete();
    endtask

    task automatic test_deal();
        int n;
        start_deal();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL t2_busy: got %b required 1", bus.busy); end
        wait_valid("t2", 0, n);
        check_deal("t2", n, t2_hand);
        t2_lat = n;
        checks++;
        if (n < 53 || n > 3215) begin errors++; $display("FAIL t2_lat_range: got %0d required 53..3215", n); end
    endtask

    task automatic test_ignore_busy();
        int              n;
        logic [9:0][5:0] eh;
        reset_dut();
        start_deal();
        n = 0;
        repeat (5) begin @(negedge clk); n++; end
        bus.deal = 1'b1;
        @(negedge clk); n++;
        bus.deal = 1'b0;
        repeat (34) begin @(negedge clk); n++; end
        bus.deal = 1'b1;
        @(negedge clk); n++;
        bus.deal = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL t3_busy: got %b required 1", bus.busy); end
        wait_valid("t3", n, n);
        check_deal("t3", n, eh);
        checks++;
        if (n !== t2_lat) begin errors++; $display("FAIL t3_same_lat: got %0d required %0d", n, t2_lat); end
        checks++;
        if (get_hand() !== t2_hand) begin errors++; $display("FAIL t3_same_hand: got %h required %h", get_hand(), t2_hand); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL t3_no_queue: got valid=%b busy=%b required valid=1 busy=0", bus.valid, bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        int              n;
        logic [9:0][5:0] eh;
        reset_dut();
        start_deal();
        repeat (20) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL t4_busy_before: got %b required 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || get_hand() !== '0) begin
            errors++;
            $display("FAIL t4_async: got busy=%b valid=%b hand=%h required all 0", bus.busy, bus.valid, get_hand());
        end
        checks++;
        if (dut.lfsr_q !== 6'd1) begin errors++; $display("FAIL t4_lfsr: got %0d required 1", dut.lfsr_q); end
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 6'd1;
        exp_q.delete();
        start_deal();
        wait_valid("t4", 0, n);
        check_deal("t4", n, eh);
        checks++;
        if (get_hand() !== t2_hand) begin errors++; $display("FAIL t4_repro: got %h required %h", get_hand(), t2_hand); end
    endtask

    task automatic test_redeal();
        int              n;
        bit              held_ok;
        logic [9:0][5:0] old, eh;
        old = t2_hand;
        @(negedge clk);
        bus.deal = 1'b1;
        model_push();
        @(negedge clk);
        bus.deal = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_drop: got valid=%b busy=%b required valid=0 busy=1", bus.valid, bus.busy);
        end
        n = 0;
        held_ok = 1'b1;
        while (bus.valid !== 1'b1 && n < 3300) begin
            if (get_hand() !== old) held_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!held_ok) begin errors++; $display("FAIL t5_held: got a changed hand required %h until DEAL", old); end
        wait_valid("t5", n, n);
        check_deal("t5", n, eh);
    endtask

    task automatic test_back_to_back();
        localparam int NDEALS = 150;
        int              n, cov;
        bit              seen[52];
        logic [9:0][5:0] eh;
        foreach (seen[k]) seen[k] = 1'b0;
        @(negedge clk);
        bus.deal = 1'b1;
        model_push();
        @(negedge clk);
        for (int d = 0; d < NDEALS; d++) begin
            wait_valid("t6", 0, n);
            check_deal("t6", n, eh);
            checks++;
            if (n > 3215) begin errors++; $display("FAIL t6_lat_max: got %0d required <= 3215", n); end
            if (bus.a1 <= 6'd51) seen[bus.a1] = 1'b1;
            if (d == NDEALS - 1) bus.deal = 1'b0;
            else model_push();
            @(negedge clk);
        end
        cov = 0;
        foreach (seen[k]) if (seen[k]) cov++;
        $display("t6 info: a1 took %0d distinct values over %0d deals", cov, NDEALS);
    endtask

    initial begin
        bus.deal = 1'b0;
        rst = 1'b1;
        test_reset();
        test_deal();
        test_ignore_busy();
        test_mid_reset();
        test_redeal();
        test_back_to_back();
        finish_now();
    end
endmodule
